// File: rtl/mux_n_1_arb_if.sv
// Handshake/data bundle between N producers, the selector, and one consumer.
// The selector uses the slave view; the producer/consumer side uses master.
interface mux_n_1_arb_if #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);
  logic                    Mode;
  logic [SEL_W-1:0]        Sel;
  logic [NUM_IN*WIDTH-1:0] InData;
  logic [NUM_IN-1:0]       InValid;
  logic [NUM_IN-1:0]       InReady;
  logic [WIDTH-1:0]        OutData;
  logic [SEL_W-1:0]        OutSrc;
  logic                    OutValid;
  logic                    OutReady;

  modport master (
    output Mode, Sel, InData, InValid, OutReady,
    input  InReady, OutData, OutSrc, OutValid
  );

  modport slave (
    input  Mode, Sel, InData, InValid, OutReady,
    output InReady, OutData, OutSrc, OutValid
  );
endinterface

// File: rtl/mux_n_1_arb.sv
// N:1 datapath selector with explicit-select or round-robin grant and a
// single-entry registered output stage using a valid/ready handshake.
module mux_n_1_arb #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input logic           Clk,
  input logic           Rst_n,
  mux_n_1_arb_if.slave  bus
);

  logic               ld_s;
  logic               grant_s;
  logic [SEL_W-1:0]   g_s;
  logic [SEL_W:0]     scan_s;
  logic [SEL_W-1:0]   ptr_nxt_s;
  logic [WIDTH-1:0]   sel_data_s;
  logic [SEL_W-1:0]   ptr_r;
  logic [WIDTH-1:0]   data_r;
  logic [SEL_W-1:0]   src_r;
  logic               valid_r;

  assign ld_s = !valid_r || bus.OutReady;

  // Grant selection; scan_s is one bit wider so ptr+k cannot overflow before the wrap.
  always_comb begin
    grant_s = 1'b0;
    g_s     = {SEL_W{1'b0}};
    scan_s  = {(SEL_W+1){1'b0}};
    if (bus.Mode) begin
      for (int k = 0; k < NUM_IN; k++) begin
        scan_s = {1'b0, ptr_r} + (SEL_W+1)'(k);
        if (scan_s >= (SEL_W+1)'(NUM_IN)) begin
          scan_s = scan_s - (SEL_W+1)'(NUM_IN);
        end else begin
          scan_s = scan_s;
        end
        if (!grant_s && bus.InValid[scan_s[SEL_W-1:0]]) begin
          grant_s = 1'b1;
          g_s     = scan_s[SEL_W-1:0];
        end else begin
          grant_s = grant_s;
        end
      end
    end else begin
      // Out-of-range Sel simply matches no channel.
      for (int i = 0; i < NUM_IN; i++) begin
        if ((bus.Sel == SEL_W'(i)) && bus.InValid[i]) begin
          grant_s = 1'b1;
          g_s     = SEL_W'(i);
        end else begin
          grant_s = grant_s;
        end
      end
    end
  end

  // Data steering and per-channel accept strobes for the granted channel.
  always_comb begin
    sel_data_s  = {WIDTH{1'b0}};
    bus.InReady = {NUM_IN{1'b0}};
    for (int i = 0; i < NUM_IN; i++) begin
      if (g_s == SEL_W'(i)) begin
        sel_data_s     = bus.InData[i*WIDTH +: WIDTH];
        bus.InReady[i] = ld_s && grant_s;
      end else begin
        bus.InReady[i] = 1'b0;
      end
    end
  end

  assign ptr_nxt_s = (g_s == SEL_W'(NUM_IN-1)) ? {SEL_W{1'b0}} : (g_s + SEL_W'(1));

  // Output register and round-robin pointer.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data_r  <= {WIDTH{1'b0}};
      src_r   <= {SEL_W{1'b0}};
      valid_r <= 1'b0;
      ptr_r   <= {SEL_W{1'b0}};
    end else if (ld_s) begin
      if (grant_s) begin
        data_r  <= sel_data_s;
        src_r   <= g_s;
        valid_r <= 1'b1;
        if (bus.Mode) begin
          ptr_r <= ptr_nxt_s;
        end else begin
          ptr_r <= ptr_r;
        end
      end else begin
        valid_r <= 1'b0;
      end
    end else begin
      valid_r <= valid_r;
    end
  end

  assign bus.OutData  = data_r;
  assign bus.OutSrc   = src_r;
  assign bus.OutValid = valid_r;

endmodule
